l2_regs_gen: RTL and testbench
==============================

L2_REGS_GEN -- requirements
Module: l2_regs_gen

Interface
REQ-001 SHALL have parameter N_REQS, default 4: number of request-buffer entries.
REQ-002 SHALL have parameter SET_BITS, default 8: width of the flush set index.
REQ-003 SHALL have parameter WAY_BITS, default 3: width of the flush way index.
REQ-004 SHALL have parameter N_STALL, default 2: number of forward-stall channels.
REQ-005 SHALL derive RB = max(1, clog2(N_REQS)) as the request index width.
REQ-006 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have ports flag_set and flag_clr, input, 4 each: per-flag set and clear strobes. Bits: 0 ongoing_flush, 1 set_conflict, 2 ongoing_atomic, 3 evict_stall.
REQ-009 SHALL have port flags, output, 4: flag state.
REQ-010 SHALL have ports flush_start, flush_step and flush_abort, input, 1 each: flush walker controls.
REQ-011 SHALL have ports flush_set (output, SET_BITS), flush_way (output, WAY_BITS), flush_busy (output, 1) and flush_done (output, 1): walker state.
REQ-012 SHALL have ports reqs_alloc, reqs_free and err_clr, input, 1 each.
REQ-013 SHALL have ports reqs_cnt (output, RB+1: free entries), reqs_none_free (output, 1), reqs_all_free (output, 1) and reqs_err (output, 1).
REQ-014 SHALL have ports stall_set, stall_clr and stall_ended_clr, input, N_STALL each: per-channel controls.
REQ-015 SHALL have port stall_idx_wr, input, RB: index captured by stall_set.
REQ-016 SHALL have ports put_valid (input, 1), put_idx (input, RB), put_atomic (input, 1) and put_atomic_idx (input, RB): request-retire event.
REQ-017 SHALL have ports stall_active (output, N_STALL), stall_ended (output, N_STALL) and stall_idx (output, N_STALL*RB; channel c occupies bits [c*RB +: RB]).

Function
REQ-018 Each flag SHALL be cleared by its flag_clr bit, else set by its flag_set bit, else hold; clear wins when both are asserted.
REQ-019 flush_start with flush_busy=0 SHALL next cycle give flush_busy=1, flush_set=0 and flush_way=0; flush_start while busy SHALL be ignored.
REQ-020 flush_step while busy SHALL increment flush_way; when flush_way is all-ones, flush_way SHALL wrap to 0 and flush_set SHALL increment.
REQ-021 flush_step while busy with flush_set and flush_way both all-ones SHALL next cycle give flush_busy=0, flush_set=0, flush_way=0 and flush_done=1.
REQ-022 flush_done SHALL be a single-cycle pulse and SHALL be 0 otherwise.
REQ-023 flush_abort SHALL override start and step: next cycle flush_busy=0, flush_set=0, flush_way=0 and no flush_done.
REQ-024 flush_step while idle SHALL be ignored.
REQ-025 reqs_alloc alone SHALL decrement reqs_cnt; reqs_free alone SHALL increment it; both together SHALL leave it unchanged.
REQ-026 reqs_alloc alone with reqs_cnt=0, or reqs_free alone with reqs_cnt=N_REQS, SHALL leave reqs_cnt unchanged and set reqs_err.
REQ-027 reqs_err SHALL be sticky and cleared by err_clr; a new error in the same cycle as err_clr SHALL win.
REQ-028 reqs_none_free SHALL equal (reqs_cnt==0) and reqs_all_free SHALL equal (reqs_cnt==N_REQS), combinationally.
REQ-029 Channel c match SHALL be: put_valid & stall_active[c] & (put_idx==stall_idx[c] | (put_atomic & put_atomic_idx==stall_idx[c])).
REQ-030 stall_set[c] SHALL take top priority: next cycle stall_active[c]=1, stall_idx[c]=stall_idx_wr and stall_ended[c]=0.
REQ-031 Otherwise a match SHALL next cycle give stall_ended[c]=1 and stall_active[c]=0.
REQ-032 Otherwise stall_clr[c] SHALL clear stall_active[c], and stall_ended_clr[c] SHALL clear stall_ended[c]; a match SHALL beat stall_ended_clr in the same cycle.
REQ-033 One put event SHALL be able to match several channels in the same cycle.
REQ-034 All arithmetic SHALL be unsigned, and no counter SHALL wrap except flush_way as defined in REQ-020.

Reset
REQ-035 While rst=0, the block SHALL hold: flags=0, flush_busy=0, flush_done=0, flush_set=0, flush_way=0, reqs_cnt=N_REQS, reqs_err=0, stall_active=0, stall_ended=0, stall_idx=0.
REQ-036 Reset assertion mid-flush or mid-stall SHALL abort immediately with no flush_done pulse.
REQ-037 On the first clock edge after rst deasserts, the block SHALL respond to inputs.

Verification (bench parameters: N_REQS=4, SET_BITS=2, WAY_BITS=1, N_STALL=2)
REQ-038 Start then 8 steps -> (set,way) sequence 0,0 0,1 1,0 ... 3,1; after the 8th step, busy=0 and flush_done high for exactly 1 cycle.
REQ-039 Start, 3 steps, abort with a step in the same cycle -> busy=0, set=0, way=0, flush_done never asserted.
REQ-040 5 allocs -> reqs_cnt 3,2,1,0,0; reqs_err=1 after the 5th; alloc+free together at 0 -> reqs_cnt stays 0; err_clr -> reqs_err=0.
REQ-041 Set ch0 idx=2 and ch1 idx=2, then put_valid with put_idx=2 -> both stall_ended=1 and both stall_active=0; stall_ended_clr[0] together with a new match on ch0 -> stall_ended[0] stays 1.
REQ-042 Set ch0 idx=1, then put with put_idx=3, put_atomic=1, put_atomic_idx=1 -> stall_ended[0]=1; same put with put_atomic=0 -> no change.
REQ-043 flag_set=flag_clr=4'b0101 -> flags=0; then rst pulsed low mid-flush -> all outputs at their REQ-035 reset values.

Source files
------------

// File: rtl/l2_regs_gen.sv
// L2 control register block: status flags, flush set/way walker, request-buffer
// free counter with sticky error, and forward-stall channels released by retire events.
module l2_regs_gen #(
  parameter int unsigned N_REQS   = 4,
  parameter int unsigned SET_BITS = 8,
  parameter int unsigned WAY_BITS = 3,
  parameter int unsigned N_STALL  = 2,
  localparam int unsigned RB      = (N_REQS > 2) ? $clog2(N_REQS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [3:0]            flag_set,
  input  logic [3:0]            flag_clr,
  output logic [3:0]            flags,

  input  logic                  flush_start,
  input  logic                  flush_step,
  input  logic                  flush_abort,
  output logic [SET_BITS-1:0]   flush_set,
  output logic [WAY_BITS-1:0]   flush_way,
  output logic                  flush_busy,
  output logic                  flush_done,

  input  logic                  reqs_alloc,
  input  logic                  reqs_free,
  input  logic                  err_clr,
  output logic [RB:0]           reqs_cnt,
  output logic                  reqs_none_free,
  output logic                  reqs_all_free,
  output logic                  reqs_err,

  input  logic [N_STALL-1:0]    stall_set,
  input  logic [N_STALL-1:0]    stall_clr,
  input  logic [N_STALL-1:0]    stall_ended_clr,
  input  logic [RB-1:0]         stall_idx_wr,
  input  logic                  put_valid,
  input  logic [RB-1:0]         put_idx,
  input  logic                  put_atomic,
  input  logic [RB-1:0]         put_atomic_idx,
  output logic [N_STALL-1:0]    stall_active,
  output logic [N_STALL-1:0]    stall_ended,
  output logic [N_STALL*RB-1:0] stall_idx
);

  localparam logic [RB:0] ReqsMax = (RB+1)'(N_REQS);
  localparam logic [RB:0] CntOne  = (RB+1)'(1);

  // Flags: clear beats set.
  logic [3:0] flags_q, flags_d;

  assign flags_d = (flags_q | flag_set) & ~flag_clr;

  // Flush walker
  logic [SET_BITS-1:0] flush_set_q, flush_set_d;
  logic [WAY_BITS-1:0] flush_way_q, flush_way_d;
  logic                flush_busy_q, flush_busy_d;
  logic                flush_done_q, flush_done_d;

  always_comb begin
    flush_set_d  = flush_set_q;
    flush_way_d  = flush_way_q;
    flush_busy_d = flush_busy_q;
    flush_done_d = 1'b0;
    if (flush_abort) begin
      flush_set_d  = '0;
      flush_way_d  = '0;
      flush_busy_d = 1'b0;
    end else if (!flush_busy_q) begin
      if (flush_start) begin
        flush_set_d  = '0;
        flush_way_d  = '0;
        flush_busy_d = 1'b1;
      end
    end else if (flush_step) begin
      if (&flush_way_q) begin
        flush_way_d = '0;
        if (&flush_set_q) begin
          // Last (set, way) visited: return to idle and pulse done.
          flush_set_d  = '0;
          flush_busy_d = 1'b0;
          flush_done_d = 1'b1;
        end else begin
          flush_set_d = flush_set_q + SET_BITS'(1);
        end
      end else begin
        flush_way_d = flush_way_q + WAY_BITS'(1);
      end
    end
  end

  // Request-buffer free counter; illegal moves saturate and raise the sticky error.
  logic [RB:0] reqs_cnt_q, reqs_cnt_d;
  logic        reqs_err_q, reqs_err_d;

  always_comb begin
    reqs_cnt_d = reqs_cnt_q;
    reqs_err_d = reqs_err_q & ~err_clr;
    if (reqs_alloc && !reqs_free) begin
      if (reqs_cnt_q == '0) begin
        reqs_err_d = 1'b1;
      end else begin
        reqs_cnt_d = reqs_cnt_q - CntOne;
      end
    end else if (reqs_free && !reqs_alloc) begin
      if (reqs_cnt_q == ReqsMax) begin
        reqs_err_d = 1'b1;
      end else begin
        reqs_cnt_d = reqs_cnt_q + CntOne;
      end
    end
  end

  // Forward-stall channels
  logic [N_STALL-1:0]    stall_active_q, stall_active_d;
  logic [N_STALL-1:0]    stall_ended_q, stall_ended_d;
  logic [N_STALL*RB-1:0] stall_idx_q, stall_idx_d;
  logic [N_STALL-1:0]    stall_match;

  always_comb begin
    stall_match = '0;
    for (int c = 0; c < N_STALL; c++) begin
      stall_match[c] = put_valid & stall_active_q[c] &
                       ((put_idx == stall_idx_q[c*RB +: RB]) |
                        (put_atomic & (put_atomic_idx == stall_idx_q[c*RB +: RB])));
    end
  end

  always_comb begin
    stall_active_d = stall_active_q;
    stall_ended_d  = stall_ended_q;
    stall_idx_d    = stall_idx_q;
    for (int c = 0; c < N_STALL; c++) begin
      if (stall_set[c]) begin
        stall_active_d[c]         = 1'b1;
        stall_ended_d[c]          = 1'b0;
        stall_idx_d[c*RB +: RB]   = stall_idx_wr;
      end else if (stall_match[c]) begin
        stall_active_d[c] = 1'b0;
        stall_ended_d[c]  = 1'b1;
      end else begin
        if (stall_clr[c]) begin
          stall_active_d[c] = 1'b0;
        end
        if (stall_ended_clr[c]) begin
          stall_ended_d[c] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags_q        <= '0;
      flush_set_q    <= '0;
      flush_way_q    <= '0;
      flush_busy_q   <= 1'b0;
      flush_done_q   <= 1'b0;
      reqs_cnt_q     <= ReqsMax;
      reqs_err_q     <= 1'b0;
      stall_active_q <= '0;
      stall_ended_q  <= '0;
      stall_idx_q    <= '0;
    end else begin
      flags_q        <= flags_d;
      flush_set_q    <= flush_set_d;
      flush_way_q    <= flush_way_d;
      flush_busy_q   <= flush_busy_d;
      flush_done_q   <= flush_done_d;
      reqs_cnt_q     <= reqs_cnt_d;
      reqs_err_q     <= reqs_err_d;
      stall_active_q <= stall_active_d;
      stall_ended_q  <= stall_ended_d;
      stall_idx_q    <= stall_idx_d;
    end
  end

  assign flags          = flags_q;
  assign flush_set      = flush_set_q;
  assign flush_way      = flush_way_q;
  assign flush_busy     = flush_busy_q;
  assign flush_done     = flush_done_q;
  assign reqs_cnt       = reqs_cnt_q;
  assign reqs_err       = reqs_err_q;
  assign reqs_none_free = (reqs_cnt_q == '0);
  assign reqs_all_free  = (reqs_cnt_q == ReqsMax);
  assign stall_active   = stall_active_q;
  assign stall_ended    = stall_ended_q;
  assign stall_idx      = stall_idx_q;

endmodule

// File: tb/tb_l2_regs_gen.sv
// Directed bench for l2_regs_gen with N_REQS=4, SET_BITS=2, WAY_BITS=1, N_STALL=2.
module tb_l2_regs_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] flag_set, flag_clr, flags;
  logic       flush_start, flush_step, flush_abort;
  logic [1:0] flush_set;
  logic [0:0] flush_way;
  logic       flush_busy, flush_done;
  logic       reqs_alloc, reqs_free, err_clr;
  logic [2:0] reqs_cnt;
  logic       reqs_none_free, reqs_all_free, reqs_err;
  logic [1:0] stall_set, stall_clr, stall_ended_clr;
  logic [1:0] stall_idx_wr;
  logic       put_valid, put_atomic;
  logic [1:0] put_idx, put_atomic_idx;
  logic [1:0] stall_active, stall_ended;
  logic [3:0] stall_idx;

  int unsigned errors = 0;
  int unsigned checks = 0;

  l2_regs_gen #(
    .N_REQS  (4),
    .SET_BITS(2),
    .WAY_BITS(1),
    .N_STALL (2)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .flag_set       (flag_set),
    .flag_clr       (flag_clr),
    .flags          (flags),
    .flush_start    (flush_start),
    .flush_step     (flush_step),
    .flush_abort    (flush_abort),
    .flush_set      (flush_set),
    .flush_way      (flush_way),
    .flush_busy     (flush_busy),
    .flush_done     (flush_done),
    .reqs_alloc     (reqs_alloc),
    .reqs_free      (reqs_free),
    .err_clr        (err_clr),
    .reqs_cnt       (reqs_cnt),
    .reqs_none_free (reqs_none_free),
    .reqs_all_free  (reqs_all_free),
    .reqs_err       (reqs_err),
    .stall_set      (stall_set),
    .stall_clr      (stall_clr),
    .stall_ended_clr(stall_ended_clr),
    .stall_idx_wr   (stall_idx_wr),
    .put_valid      (put_valid),
    .put_idx        (put_idx),
    .put_atomic     (put_atomic),
    .put_atomic_idx (put_atomic_idx),
    .stall_active   (stall_active),
    .stall_ended    (stall_ended),
    .stall_idx      (stall_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flag_set = '0; flag_clr = '0;
    flush_start = 1'b0; flush_step = 1'b0; flush_abort = 1'b0;
    reqs_alloc = 1'b0; reqs_free = 1'b0; err_clr = 1'b0;
    stall_set = '0; stall_clr = '0; stall_ended_clr = '0; stall_idx_wr = '0;
    put_valid = 1'b0; put_idx = '0; put_atomic = 1'b0; put_atomic_idx = '0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".flags"},  32'(flags), 32'h0);
    check({tag, ".busy"},   32'(flush_busy), 32'h0);
    check({tag, ".done"},   32'(flush_done), 32'h0);
    check({tag, ".set"},    32'(flush_set), 32'h0);
    check({tag, ".way"},    32'(flush_way), 32'h0);
    check({tag, ".cnt"},    32'(reqs_cnt), 32'd4);
    check({tag, ".err"},    32'(reqs_err), 32'h0);
    check({tag, ".none"},   32'(reqs_none_free), 32'h0);
    check({tag, ".all"},    32'(reqs_all_free), 32'h1);
    check({tag, ".active"}, 32'(stall_active), 32'h0);
    check({tag, ".ended"},  32'(stall_ended), 32'h0);
    check({tag, ".sidx"},   32'(stall_idx), 32'h0);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    tick();
    tick();
    check_reset("rst0");
    rst = 1'b1;

    // Flags: clear wins over set
    flag_set = 4'b0101; flag_clr = 4'b0101;
    tick();
    check("flags_both", 32'(flags), 32'h0);
    flag_set = 4'b1111; flag_clr = 4'b0000;
    tick();
    check("flags_set", 32'(flags), 32'hf);
    flag_set = 4'b0101; flag_clr = 4'b0101;
    tick();
    check("flags_hold_clr", 32'(flags), 32'ha);
    flag_set = 4'b0000; flag_clr = 4'b1010;
    tick();
    check("flags_clr", 32'(flags), 32'h0);
    flag_clr = 4'b0000;

    // Full flush walk
    flush_start = 1'b1;
    tick();
    flush_start = 1'b0;
    check("fl_start_busy", 32'(flush_busy), 32'h1);
    check("fl_start_pos", 32'({flush_set, flush_way}), 32'h0);
    flush_step = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k < 8) begin
        check($sformatf("fl_pos%0d", k), 32'({flush_set, flush_way}), 32'(k));
        check($sformatf("fl_busy%0d", k), 32'(flush_busy), 32'h1);
        check($sformatf("fl_done%0d", k), 32'(flush_done), 32'h0);
      end else begin
        check("fl_end_busy", 32'(flush_busy), 32'h0);
        check("fl_end_done", 32'(flush_done), 32'h1);
        check("fl_end_pos", 32'({flush_set, flush_way}), 32'h0);
      end
    end
    // Step stays high while idle: ignored, done drops
    tick();
    check("fl_idle_step_done", 32'(flush_done), 32'h0);
    check("fl_idle_step_busy", 32'(flush_busy), 32'h0);
    check("fl_idle_step_pos", 32'({flush_set, flush_way}), 32'h0);
    flush_step = 1'b0;

    // Abort after 3 steps, with a step in the same cycle; start while busy ignored
    flush_start = 1'b1;
    tick();
    flush_start = 1'b0;
    flush_step = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      flush_start = (k == 2);
      tick();
      check($sformatf("ab_pos%0d", k), 32'({flush_set, flush_way}), 32'(k));
      check($sformatf("ab_done%0d", k), 32'(flush_done), 32'h0);
    end
    flush_start = 1'b0;
    flush_abort = 1'b1;
    tick();
    flush_abort = 1'b0;
    flush_step = 1'b0;
    check("ab_busy", 32'(flush_busy), 32'h0);
    check("ab_pos", 32'({flush_set, flush_way}), 32'h0);
    check("ab_done", 32'(flush_done), 32'h0);
    tick();
    check("ab_done_after", 32'(flush_done), 32'h0);

    // Request counter
    reqs_alloc = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("rq_cnt%0d", k), 32'(reqs_cnt), (k < 4) ? 32'(4 - k) : 32'h0);
      check($sformatf("rq_err%0d", k), 32'(reqs_err), (k == 5) ? 32'h1 : 32'h0);
    end
    check("rq_none", 32'(reqs_none_free), 32'h1);
    reqs_free = 1'b1;
    tick();
    check("rq_both_cnt", 32'(reqs_cnt), 32'h0);
    check("rq_both_err", 32'(reqs_err), 32'h1);
    reqs_alloc = 1'b0; reqs_free = 1'b0; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("rq_errclr", 32'(reqs_err), 32'h0);
    reqs_free = 1'b1;
    repeat (4) tick();
    check("rq_full_cnt", 32'(reqs_cnt), 32'd4);
    check("rq_full_all", 32'(reqs_all_free), 32'h1);
    check("rq_full_err", 32'(reqs_err), 32'h0);
    err_clr = 1'b1;
    tick();
    reqs_free = 1'b0; err_clr = 1'b0;
    check("rq_over_cnt", 32'(reqs_cnt), 32'd4);
    check("rq_over_err", 32'(reqs_err), 32'h1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("rq_errclr2", 32'(reqs_err), 32'h0);

    // Stall channels: one put matches both
    stall_set = 2'b11; stall_idx_wr = 2'd2;
    tick();
    stall_set = 2'b00;
    check("st_set_active", 32'(stall_active), 32'h3);
    check("st_set_idx", 32'(stall_idx), 32'ha);
    put_valid = 1'b1; put_idx = 2'd2;
    tick();
    put_valid = 1'b0;
    check("st_m2_ended", 32'(stall_ended), 32'h3);
    check("st_m2_active", 32'(stall_active), 32'h0);
    stall_set = 2'b01;
    tick();
    stall_set = 2'b00;
    check("st_reset_ended", 32'(stall_ended), 32'h2);
    check("st_reset_active", 32'(stall_active), 32'h1);
    put_valid = 1'b1; stall_ended_clr = 2'b01;
    tick();
    put_valid = 1'b0; stall_ended_clr = 2'b00;
    check("st_match_beats_eclr", 32'(stall_ended), 32'h3);
    stall_ended_clr = 2'b11;
    tick();
    stall_ended_clr = 2'b00;
    check("st_eclr", 32'(stall_ended), 32'h0);

    // Atomic index match
    stall_set = 2'b01; stall_idx_wr = 2'd1;
    tick();
    stall_set = 2'b00;
    put_valid = 1'b1; put_idx = 2'd3; put_atomic = 1'b1; put_atomic_idx = 2'd1;
    tick();
    put_valid = 1'b0;
    check("st_atom_ended", 32'(stall_ended), 32'h1);
    check("st_atom_active", 32'(stall_active), 32'h0);
    stall_set = 2'b01;
    tick();
    stall_set = 2'b00;
    put_valid = 1'b1; put_atomic = 1'b0;
    tick();
    put_valid = 1'b0;
    check("st_noatom_ended", 32'(stall_ended), 32'h0);
    check("st_noatom_active", 32'(stall_active), 32'h1);
    stall_clr = 2'b01;
    tick();
    stall_clr = 2'b00;
    check("st_clr", 32'(stall_active), 32'h0);

    // Asynchronous reset mid-flush and mid-stall
    flush_start = 1'b1;
    flag_set = 4'b1111;
    stall_set = 2'b11; stall_idx_wr = 2'd3;
    reqs_alloc = 1'b1;
    tick();
    idle_inputs();
    flush_step = 1'b1;
    tick();
    tick();
    tick();
    check("pre_rst_busy", 32'(flush_busy), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check_reset("rst_async");
    tick();
    check_reset("rst_held");
    flush_step = 1'b0;
    rst = 1'b1;
    flag_set = 4'b0001; flush_start = 1'b1;
    tick();
    idle_inputs();
    check("post_rst_flags", 32'(flags), 32'h1);
    check("post_rst_busy", 32'(flush_busy), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
